// File: rtl/mc_sequencer.sv
// Multi-cycle CPU sequencer: one-hot FSM driving fetch/decode/execute strobes,
// data-memory req/ack with timeout, interrupt entry and a latched CP0 cause code.
module mc_sequencer #(
  parameter int unsigned        INSTR_W     = 54,
  parameter logic [INSTR_W-1:0] JUMP_MASK   = INSTR_W'(54'h0000_0000_0001_0000),
  parameter logic [INSTR_W-1:0] TRAP_MASK   = INSTR_W'(54'h2F_0000_0000_0000),
  parameter logic [INSTR_W-1:0] MEM_MASK    = INSTR_W'(54'h0000_FF00_0000_0000),
  parameter logic [INSTR_W-1:0] WB_MASK     = INSTR_W'(54'h0000_1F00_07FE_FFFF),
  parameter int unsigned        SYSCALL_BIT = 51,
  parameter int unsigned        TEQ_BIT     = 52,
  parameter int unsigned        BREAK_BIT   = 53,
  parameter int unsigned        MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] decoded_instr,
  input  logic               zero,
  input  logic               mem_ack,
  input  logic               irq,
  input  logic               irq_ena,
  output logic               pc_ena,
  output logic               ir_in,
  output logic               decode_ena,
  output logic               zin,
  output logic               zout,
  output logic               npc_in,
  output logic               regfile_w,
  output logic               mem_req,
  output logic               cp0_ena,
  output logic [4:0]         cp0_cause,
  output logic [5:0]         state
);

  localparam int unsigned          CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [5:0] {
    S_IF  = 6'b000001,
    S_ID  = 6'b000010,
    S_EX  = 6'b000100,
    S_MEM = 6'b001000,
    S_WB  = 6'b010000,
    S_EXC = 6'b100000
  } state_t;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       cause, cause_nxt;
  logic             fetch_stb, id_stb, mem_stb, wb_stb, exc_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur   <= S_IF;
      cnt   <= '0;
      cause <= '0;
    end else begin
      cur   <= nxt;
      // cause_nxt only departs from cause on transitions into EXC
      cause <= cause_nxt;
      cnt   <= (cur == S_MEM && nxt == S_MEM) ? cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    nxt       = S_IF;
    cause_nxt = cause;
    fetch_stb = 1'b0;
    id_stb    = 1'b0;
    mem_stb   = 1'b0;
    wb_stb    = 1'b0;
    exc_stb   = 1'b0;
    case (cur)
      S_IF: begin
        if (irq && irq_ena) begin
          nxt       = S_EXC;
          cause_nxt = 5'd0;
        end else begin
          fetch_stb = 1'b1;
          nxt       = S_ID;
        end
      end
      S_ID: begin
        id_stb = 1'b1;
        if (|(decoded_instr & JUMP_MASK)) begin
          nxt = S_IF;
        end else if (|(decoded_instr & TRAP_MASK)) begin
          nxt = S_EXC;
          if (decoded_instr[SYSCALL_BIT])    cause_nxt = 5'd8;
          else if (decoded_instr[BREAK_BIT]) cause_nxt = 5'd9;
          else                               cause_nxt = 5'd0;
        end else if (decoded_instr == '0) begin
          nxt = S_IF;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (decoded_instr[TEQ_BIT]) begin
          if (zero) begin
            nxt       = S_EXC;
            cause_nxt = 5'd13;
          end else begin
            nxt = S_IF;
          end
        end else if (|(decoded_instr & MEM_MASK)) begin
          nxt = S_MEM;
        end else if (|(decoded_instr & WB_MASK)) begin
          nxt = S_WB;
        end else begin
          nxt = S_IF;
        end
      end
      S_MEM: begin
        mem_stb = 1'b1;
        // ack in the final wait cycle takes precedence over the bus-error trap
        if (mem_ack) begin
          nxt = (|(decoded_instr & WB_MASK)) ? S_WB : S_IF;
        end else if (cnt == CNT_LAST) begin
          nxt       = S_EXC;
          cause_nxt = 5'd7;
        end else begin
          nxt = S_MEM;
        end
      end
      S_WB: begin
        wb_stb = 1'b1;
        nxt    = S_IF;
      end
      S_EXC: begin
        exc_stb = 1'b1;
        nxt     = S_IF;
      end
      default: nxt = S_IF;
    endcase
  end

  assign pc_ena     = rst & fetch_stb;
  assign ir_in      = rst & fetch_stb;
  assign decode_ena = rst & fetch_stb;
  assign zin        = rst & fetch_stb;
  assign zout       = rst & id_stb;
  assign npc_in     = rst & (id_stb | exc_stb);
  assign regfile_w  = rst & wb_stb;
  assign mem_req    = rst & mem_stb;
  assign cp0_ena    = rst & exc_stb;
  assign cp0_cause  = cause;
  assign state      = cur;

endmodule
